// File: rtl/gcd_scheduler.sv
// ---------------------------------------------------------------------------
// gcd_scheduler
//
// Time-shares one iterative subtraction-based GCD engine between N_REQ
// requesters. In IDLE a round-robin arbiter (search starts at ptr, wraps)
// grants one pending request. The winner's operands are loaded into the
// Euclid datapath, which performs one compare/subtract per cycle until
// termination. The result is then held on a valid/ready response channel
// until it is accepted.
//
// Ports
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   req_valid   : per-requester request valid                  [N_REQ]
//   req_x/req_y : operands, requester i at bits [i*W +: W]      [N_REQ*W]
//   req_ready   : one-hot (or zero) grant, combinational in IDLE [N_REQ]
//   rsp_valid   : result available (DONE state)
//   rsp_ready   : consumer accepts result
//   rsp_id      : requester index the result belongs to         [IDW]
//   rsp_gcd     : GCD result                                    [W]
//   rsp_iters   : subtraction steps, saturating at 2^W-1        [W]
//   rsp_err     : both operands were zero
//   busy        : high whenever the engine is not IDLE
// ---------------------------------------------------------------------------
module gcd_scheduler #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_x,
  input  logic [N_REQ*W-1:0] req_y,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [W-1:0]       rsp_gcd,
  output logic [W-1:0]       rsp_iters,
  output logic               rsp_err,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [W-1:0]   a;
  logic [W-1:0]   b;

  // Arbiter results
  logic [IDW:0]   scan_pos;
  logic [IDW-1:0] win;
  logic           accept;
  logic [W-1:0]   op_x;
  logic [W-1:0]   op_y;

  // Round-robin search from ptr upward with wrap. scan_pos is one bit wider
  // than an ID so ptr+k cannot overflow before the wrap subtraction.
  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so no path leaves a value held (no latch).
  always_comb begin
    req_ready = '0;
    win       = '0;
    accept    = 1'b0;
    scan_pos  = '0;
    if (state == IDLE) begin
      for (int k = 0; k < N_REQ; k++) begin
        scan_pos = {1'b0, ptr} + (IDW+1)'(k);
        if (scan_pos >= (IDW+1)'(N_REQ)) begin
          scan_pos = scan_pos - (IDW+1)'(N_REQ);
        end
        if (!accept && req_valid[scan_pos[IDW-1:0]]) begin
          req_ready[scan_pos[IDW-1:0]] = 1'b1;
          win                          = scan_pos[IDW-1:0];
          accept                       = 1'b1;
        end
      end
    end
  end

  // Operand select for the granted requester.
  always_comb begin
    op_x = '0;
    op_y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IDW'(i)) begin
        op_x = req_x[i*W +: W];
        op_y = req_y[i*W +: W];
      end
    end
  end

  // Control FSM and Euclid datapath. rsp_iters is the live step counter;
  // it is cleared on accept and only moves in ITER, so it is stable in DONE.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the operand registers are reset along with the control state; an
  // in-flight job is simply dropped and the datapath restarts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      a         <= '0;
      b         <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_gcd   <= '0;
      rsp_iters <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a         <= op_x;
            b         <= op_y;
            rsp_id    <= win;
            rsp_gcd   <= '0;
            rsp_iters <= '0;
            rsp_err   <= 1'b0;
            ptr       <= (win == IDW'(N_REQ-1)) ? '0 : win + IDW'(1);
            busy      <= 1'b1;
            state     <= ITER;
          end
        end

        ITER: begin
          if (a == '0 || b == '0) begin
            rsp_gcd   <= a | b;
            rsp_err   <= (a == '0) && (b == '0);
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else if (a == b) begin
            rsp_gcd   <= a;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            // The larger operand is always the minuend, so no underflow.
            if (a > b) begin
              a <= a - b;
            end else begin
              b <= b - a;
            end
            if (rsp_iters != '1) begin
              rsp_iters <= rsp_iters + W'(1);
            end
          end
        end

        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_gcd_scheduler
//
// Scoreboard bench for gcd_scheduler (N_REQ=4, W=8). A driver applies one
// cycle of stimulus per falling edge from per-requester job queues, predicts
// the round-robin grant, and on every grant pushes the expected response
// (GCD from Euclid's remainder form, step count from the quotient sum,
// latency) into a queue. An independent monitor pops and compares whenever
// the DUT completes a response handshake.
// ---------------------------------------------------------------------------
module tb_gcd_scheduler;

  localparam int N_REQ = 4;
  localparam int W     = 8;
  localparam int IDW   = 2;

  logic               clk;
  logic               rst_n;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_x;
  logic [N_REQ*W-1:0] req_y;
  logic [N_REQ-1:0]   req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [W-1:0]       rsp_gcd;
  logic [W-1:0]       rsp_iters;
  logic               rsp_err;
  logic               busy;

  gcd_scheduler #(.N_REQ(N_REQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gcd   (rsp_gcd),
    .rsp_iters (rsp_iters),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int gcd;
    int iters;
    int err;
    int acc;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Requester job queues and stimulus controls
  int job_x[N_REQ][$];
  int job_y[N_REQ][$];
  bit drop_en  = 1'b0;
  int rdy_mode = 1;     // 0: hold low, 1: hold high, 2: random
  int grant_log[$];     // DUT grants as observed on req_ready

  // Reference state
  bit m_busy = 1'b0;
  int m_ptr  = 0;
  int m_done = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // GCD via remainders; subtraction steps = sum of quotients minus the
  // final one (the last division stops at equality, not at zero).
  function automatic void ref_gcd(input int x, input int y,
                                  output int g, output int it, output int er);
    int p, q, t;
    er = (x == 0 && y == 0) ? 1 : 0;
    it = 0;
    if (x == 0 || y == 0) begin
      g = x | y;
    end else begin
      p = x;
      q = y;
      while (q != 0) begin
        it += p / q;
        t = p % q;
        p = q;
        q = t;
      end
      g  = p;
      it = it - 1;
      if (it > 255) it = 255;
    end
  endfunction

  // One cycle of stimulus plus grant prediction.
  task automatic tick();
    logic [N_REQ-1:0] v;
    int g, idx, eg, ei, ee;
    exp_t e;
    @(negedge clk);
    v = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (job_x[i].size() > 0) begin
        v[i] = !(drop_en && $urandom_range(0, 3) == 0);
        req_x[i*W +: W] = W'(job_x[i][0]);
        req_y[i*W +: W] = W'(job_y[i][0]);
      end else begin
        req_x[i*W +: W] = W'($urandom);
        req_y[i*W +: W] = W'($urandom);
      end
    end
    req_valid = v;
    case (rdy_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = ($urandom_range(0, 3) != 0);
    endcase
    #1;
    for (int i = 0; i < N_REQ; i++) if (req_ready[i]) grant_log.push_back(i);
    if (m_busy) begin
      check("req_ready_while_busy", int'(req_ready), 0);
      check("busy_high", int'(busy), 1);
      if (cyc >= m_done && rsp_ready) m_busy = 1'b0;
    end else begin
      g = -1;
      for (int k = 0; k < N_REQ; k++) begin
        idx = (m_ptr + k) % N_REQ;
        if (g < 0 && v[idx]) g = idx;
      end
      check("busy_low", int'(busy), 0);
      check("req_ready_grant", int'(req_ready), (g < 0) ? 0 : (1 << g));
      if (g >= 0) begin
        ref_gcd(job_x[g][0], job_y[g][0], eg, ei, ee);
        e.id = g; e.gcd = eg; e.iters = ei; e.err = ee;
        e.acc = cyc + 1; e.lat = ei + 1;
        sb.push_back(e);
        void'(job_x[g].pop_front());
        void'(job_y[g].pop_front());
        m_busy = 1'b1;
        m_ptr  = (g + 1) % N_REQ;
        m_done = cyc + 1 + ei + 1;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    bit pend = 1'b1;
    while (pend && n < budget) begin
      tick();
      n++;
      pend = m_busy;
      for (int i = 0; i < N_REQ; i++) if (job_x[i].size() > 0) pend = 1'b1;
    end
    if (pend) fail_now("wait_idle_timeout");
    tick();
    tick();
  endtask

  // Asynchronous reset: outputs must clear immediately, before any edge.
  task automatic do_reset();
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_id",    int'(rsp_id),    0);
    check("rst_rsp_gcd",   int'(rsp_gcd),   0);
    check("rst_rsp_iters", int'(rsp_iters), 0);
    check("rst_rsp_err",   int'(rsp_err),   0);
    check("rst_busy",      int'(busy),      0);
    check("rst_req_ready", int'(req_ready), 0);
    sb.delete();
    m_busy = 1'b0;
    m_ptr  = 0;
    @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic push_job(input int r, input int x, input int y);
    job_x[r].push_back(x);
    job_y[r].push_back(y);
  endtask

  // Monitor: pops the scoreboard on each response handshake, and checks
  // hold-while-stalled and one-cycle-after-accept behaviour.
  initial begin
    bit seen = 1'b0, prev_v = 1'b0, prev_hs = 1'b0;
    int rise = 0, p_id = 0, p_gcd = 0, p_it = 0, p_err = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        seen = 1'b0; prev_v = 1'b0; prev_hs = 1'b0;
        continue;
      end
      if (prev_hs) check("rsp_one_cycle", int'(rsp_valid), 0);
      if (rsp_valid) begin
        if (prev_v && !prev_hs) begin
          check("hold_id",    int'(rsp_id),    p_id);
          check("hold_gcd",   int'(rsp_gcd),   p_gcd);
          check("hold_iters", int'(rsp_iters), p_it);
          check("hold_err",   int'(rsp_err),   p_err);
        end
        if (!seen) begin
          seen = 1'b1;
          rise = cyc;
        end
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_rsp", int'(rsp_valid), 0);
          end else begin
            e = sb.pop_front();
            check("rsp_id",    int'(rsp_id),    e.id);
            check("rsp_gcd",   int'(rsp_gcd),   e.gcd);
            check("rsp_iters", int'(rsp_iters), e.iters);
            check("rsp_err",   int'(rsp_err),   e.err);
            check("latency",   rise - e.acc,    e.lat);
          end
          seen = 1'b0;
        end
      end
      prev_v  = rsp_valid;
      prev_hs = rsp_valid && rsp_ready;
      p_id = int'(rsp_id); p_gcd = int'(rsp_gcd);
      p_it = int'(rsp_iters); p_err = int'(rsp_err);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc;
    int exp_order[5];
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b1;
    do_reset();

    // Single job and boundary operands
    push_job(0, 108, 224);
    wait_idle(100);
    push_job(1, 12, 12);
    wait_idle(50);
    push_job(2, 0, 5);
    wait_idle(50);
    push_job(3, 0, 0);
    wait_idle(50);
    push_job(0, 255, 1);
    wait_idle(400);
    push_job(2, 1, 255);
    wait_idle(400);

    // Fairness: all requesters pending from reset
    do_reset();
    grant_log.delete();
    push_job(0, 48, 18);
    push_job(1, 35, 49);
    push_job(2, 81, 27);
    push_job(3, 17, 5);
    push_job(0, 100, 75);
    wait_idle(500);
    exp_order = '{0, 1, 2, 3, 0};
    check("fair_grants", grant_log.size(), 5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      check("fair_order", grant_log[k], exp_order[k]);

    // Backpressure: stall 10 cycles in DONE, then accept
    rdy_mode = 0;
    push_job(2, 60, 84);
    n = 0;
    while (!(m_busy && cyc >= m_done + 10) && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) fail_now("backpressure_wait");
    rdy_mode = 1;
    wait_idle(50);

    // Reset mid-ITER at iteration 5 of (108,224)
    push_job(0, 108, 224);
    n = 0;
    while (!m_busy && n < 50) begin
      tick();
      n++;
    end
    if (!m_busy) fail_now("midreset_accept");
    acc = (sb.size() > 0) ? sb[$].acc : cyc;
    while (cyc < acc + 5) tick();
    do_reset();
    grant_log.delete();
    push_job(0, 108, 224);
    push_job(1, 9, 6);
    wait_idle(200);
    check("post_reset_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // Randomized traffic with dropped valids and random backpressure
    drop_en  = 1'b1;
    rdy_mode = 2;
    for (int j = 0; j < 150; j++) begin
      int r = $urandom_range(0, N_REQ - 1);
      int x = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      int y = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      push_job(r, x, y);
    end
    wait_idle(60000);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gcd_scheduler.md
# gcd_scheduler

Shared-resource controller that lets several requesters time-share one iterative subtraction-based GCD engine. It arbitrates round-robin among pending requests and loads the winner's operands into an internal Euclid datapath. It sequences the datapath until termination, then returns the result with the requester ID over a valid/ready response channel. It sits between the operand sources and the single GCD datapath, so one engine serves the design instead of one per source.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `W`, 8: operand/result width.
- `IDW`, `$clog2(N_REQ)`: requester-ID width (derived).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  N_REQ: per-requester request valid.
- `req_x`  in  N_REQ*W: operand X, requester i at bits [i*W +: W].
- `req_y`  in  N_REQ*W: operand Y, same packing.
- `req_ready`  out  N_REQ: one-hot (or zero) grant/accept.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: consumer accepts result.
- `rsp_id`  out  IDW: index of requester the result belongs to.
- `rsp_gcd`  out  W: GCD result.
- `rsp_iters`  out  W: number of subtraction steps performed (saturates at 2^W-1).
- `rsp_err`  out  1: set when both operands were zero.
- `busy`  out  1: high whenever state != IDLE.

## Operation
- States: IDLE, ITER, DONE.
- IDLE: `req_ready` is combinational, one-hot on the winning requester. The winner is the first asserted `req_valid` searching from `ptr` upward with wrap. `req_ready` is all-zero if no valid.
- A transfer happens at the edge where `req_valid[i] & req_ready[i]`:
  - Capture `a<=x[i]`, `b<=y[i]`, `id<=i`, `iters<=0`.
  - Update `ptr<=(i+1) mod N_REQ`.
  - Go to ITER.
- ITER, one evaluation per cycle, first matching rule applies:
  - a==0 or b==0: result=a|b; err=(a==0 && b==0); go to DONE.
  - a==b: result=a; go to DONE.
  - a>b: a<=a-b, iters+1.
  - b>a: b<=b-a, iters+1.
- Subtraction is unsigned W-bit. Underflow cannot occur by construction.
- DONE: `rsp_valid`=1. `rsp_id`, `rsp_gcd`, `rsp_iters`, `rsp_err` are stable until the handshake. When `rsp_ready`=1 at an edge, go to IDLE.
- `req_ready` is all-zero in ITER and DONE. Requester inputs are ignored outside IDLE. Requesters hold valid and operands until granted.
- Requesters may drop `req_valid` before grant. No request is latched without a handshake.

## Timing
- Reset (async assert, sync-safe deassert), all applied immediately:
  - state=IDLE, `ptr`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_gcd`=0, `rsp_iters`=0, `rsp_err`=0, `busy`=0.
  - An in-flight job is discarded with no response.
- Latency: accept edge = edge 0. An operation needing S subtractions raises `rsp_valid` after edge S+1. Minimum latency is 1 (equal or zero operands).
- Worst case for W=8 is (255,1) or (1,255): S=254, `rsp_valid` after edge 255.
- Back-to-back operation:
  - The response handshake edge returns the block to IDLE.
  - The earliest next accept is the following edge, so there is one idle cycle of `req_ready` per job.
- `rsp_ready` held high in DONE: the response lasts exactly one cycle.
- `rsp_ready` asserted in IDLE or ITER has no effect.
- Simultaneous requests are resolved only by round-robin. No requester is granted twice while another valid requester waits.

## Test plan
- Single job, requester 0, X=108, Y=224, `rsp_ready`=1 → `rsp_valid` after edge 17, `rsp_gcd`=4, `rsp_iters`=16, `rsp_id`=0, `rsp_err`=0.
- Boundary operands:
  - (12,12) → `rsp_gcd`=12, `rsp_iters`=0, latency 1.
  - (0,5) → `rsp_gcd`=5, `rsp_err`=0.
  - (0,0) → `rsp_gcd`=0, `rsp_err`=1.
  - (255,1) → `rsp_gcd`=1, `rsp_iters`=254, latency 255.
- Fairness: all 4 requesters valid continuously after reset, each with distinct operands → grant order 0,1,2,3,0 and each `rsp_id` matches its operands' GCD.
- Backpressure: hold `rsp_ready`=0 for 10 cycles in DONE → outputs stable, `req_ready` all-zero, `busy`=1. Then `rsp_ready`=1 → one-cycle response, then IDLE.
- Reset mid-ITER: assert `rst_n`=0 at iteration 5 of (108,224) → all outputs zero immediately, no response. After release, requester 0 is granted first and completes correctly.
